// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR and trap unit.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    localparam int unsigned CODE_W = 5;

    // Cause codes double as the mip/mie bit positions of the standard sources.
    localparam logic [CODE_W-1:0] ECALL_M    = 5'd11;
    localparam logic [CODE_W-1:0] MSI        = 5'd3;
    localparam logic [CODE_W-1:0] MTI        = 5'd7;
    localparam logic [CODE_W-1:0] MEI        = 5'd11;
    localparam logic [CODE_W-1:0] LOCAL_BASE = 5'd16;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_counter.sv
// Performance counter with inhibit, increment enable and split 32-bit write ports.
module csr_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inhibit,
    input  logic                 inc_en,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] merged;
    logic [CNT_WIDTH-1:0] count_d;

    if (CNT_WIDTH > 32) begin : g_wide
        assign merged = {wr_hi ? wdata[CNT_WIDTH-33:0] : count[CNT_WIDTH-1:32],
                         wr_lo ? wdata : count[31:0]};
    end else begin : g_narrow
        assign merged = wr_lo ? CNT_WIDTH'(wdata) : count;
    end

    // A software write wins over this cycle's increment.
    always_comb begin
        count_d = count;
        if (wr_lo || wr_hi) begin
            count_d = merged;
        end else if (inc_en && !inhibit) begin
            count_d = count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode CSR file and trap/mret decision for the RV32I EX stage.
module csr_mtrap #(
    parameter int unsigned NUM_LIRQ    = 4,
    parameter int unsigned CNT_WIDTH   = 64,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_csr_ex,
    input  logic [11:0] csr_ofs_ex,
    input  logic [2:0]  csr_op2_ex,
    input  logic [4:0]  csr_uimm_ex,
    input  logic [31:0] rs1_sel,
    output logic [31:0] csr_rd_data,
    input  logic        cmd_ecall_ex,
    input  logic        cmd_mret_ex,
    input  logic [29:0] pc_ex,
    input  logic        retire,
    input  logic        stall,
    input  logic        irq_ext,
    input  logic        irq_tmr,
    input  logic        irq_sw,
    input  logic [((NUM_LIRQ > 0) ? NUM_LIRQ : 1)-1:0] irq_local,
    output logic        trap_take,
    output logic [29:0] trap_pc,
    output logic        mret_take,
    output logic [29:0] mret_pc
);
    import csr_pkg::*;

    localparam logic [31:0] MIE_MASK =
        32'h0000_0888 | 32'(((64'd1 << NUM_LIRQ) - 64'd1) << 16);

    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic        st_mie_q, st_mpie_q, cy_inh_q, ir_inh_q;

    logic [31:0]          mip, pending, operand, wdata;
    logic                 int_hit, found, csr_we;
    logic [CODE_W-1:0]    int_code;
    csr_op_e              op;
    logic [CNT_WIDTH-1:0] mcycle, minstret;
    logic [31:0]          mcycle_hi, minstret_hi;

    always_comb begin
        mip          = '0;
        mip[MEI]     = irq_ext;
        mip[MTI]     = irq_tmr;
        mip[MSI]     = irq_sw;
        for (int unsigned i = 0; i < NUM_LIRQ; i++) begin
            mip[16+i] = irq_local[i];
        end
    end

    assign pending = mip & mie_q;
    assign int_hit = (|pending) & st_mie_q;

    // Later assignments take precedence: MEI > MSI > MTI > lowest local.
    always_comb begin
        int_code = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_LIRQ; i++) begin
            if (pending[16+i] && !found) begin
                int_code = CODE_W'(32'(LOCAL_BASE) + i);
                found    = 1'b1;
            end
        end
        if (pending[MTI]) int_code = MTI;
        if (pending[MSI]) int_code = MSI;
        if (pending[MEI]) int_code = MEI;
    end

    assign trap_take = ~stall & (int_hit | cmd_ecall_ex);
    assign mret_take = ~stall & ~int_hit & ~cmd_ecall_ex & cmd_mret_ex;
    assign trap_pc   = mtvec_q[31:2] + ((mtvec_q[0] && int_hit) ? 30'(int_code) : 30'd0);
    assign mret_pc   = mepc_q[31:2];

    assign mcycle_hi   = 32'(64'(mcycle) >> 32);
    assign minstret_hi = 32'(64'(minstret) >> 32);

    always_comb begin
        csr_rd_data = '0;
        case (csr_ofs_ex)
            CSR_MSTATUS:       csr_rd_data = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            CSR_MISA:          csr_rd_data = MISA_VAL;
            CSR_MIE:           csr_rd_data = mie_q;
            CSR_MTVEC:         csr_rd_data = mtvec_q;
            CSR_MCOUNTINHIBIT: csr_rd_data = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
            CSR_MSCRATCH:      csr_rd_data = mscratch_q;
            CSR_MEPC:          csr_rd_data = mepc_q;
            CSR_MCAUSE:        csr_rd_data = mcause_q;
            CSR_MTVAL:         csr_rd_data = mtval_q;
            CSR_MIP:           csr_rd_data = mip;
            CSR_MCYCLE,   CSR_CYCLE:    csr_rd_data = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   csr_rd_data = mcycle_hi;
            CSR_MINSTRET, CSR_INSTRET:  csr_rd_data = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rd_data = minstret_hi;
            default:           csr_rd_data = '0;
        endcase
    end

    assign op      = csr_op_e'(csr_op2_ex[1:0]);
    assign operand = csr_op2_ex[2] ? 32'(csr_uimm_ex) : rs1_sel;

    // Set/clear with a zero operand is a pure read.
    always_comb begin
        wdata  = operand;
        csr_we = 1'b0;
        case (op)
            CSR_OP_RW: csr_we = 1'b1;
            CSR_OP_RS: begin
                wdata  = csr_rd_data | operand;
                csr_we = |operand;
            end
            CSR_OP_RC: begin
                wdata  = csr_rd_data & ~operand;
                csr_we = |operand;
            end
            default: csr_we = 1'b0;
        endcase
        csr_we = csr_we & cmd_csr_ex & ~stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
        end else begin
            // Trap entry owns mepc/mcause/mtval/mstatus; a colliding write is dropped.
            if (trap_take) begin
                mepc_q    <= {pc_ex, 2'b00};
                mcause_q  <= int_hit ? {1'b1, 26'b0, int_code} : {27'b0, ECALL_M};
                mtval_q   <= '0;
                st_mpie_q <= st_mie_q;
                st_mie_q  <= 1'b0;
            end else begin
                if (mret_take) begin
                    st_mie_q  <= st_mpie_q;
                    st_mpie_q <= 1'b1;
                end else if (csr_we && csr_ofs_ex == CSR_MSTATUS) begin
                    st_mie_q  <= wdata[3];
                    st_mpie_q <= wdata[7];
                end
                if (csr_we && csr_ofs_ex == CSR_MEPC)   mepc_q   <= {wdata[31:2], 2'b00};
                if (csr_we && csr_ofs_ex == CSR_MCAUSE) mcause_q <= wdata;
                if (csr_we && csr_ofs_ex == CSR_MTVAL)  mtval_q  <= wdata;
            end
            if (csr_we && csr_ofs_ex == CSR_MIE)      mie_q      <= wdata & MIE_MASK;
            if (csr_we && csr_ofs_ex == CSR_MTVEC)    mtvec_q    <= {wdata[31:2], 1'b0, wdata[1:0] == 2'b01};
            if (csr_we && csr_ofs_ex == CSR_MSCRATCH) mscratch_q <= wdata;
            if (csr_we && csr_ofs_ex == CSR_MCOUNTINHIBIT) begin
                cy_inh_q <= wdata[0];
                ir_inh_q <= wdata[2];
            end
        end
    end

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (cy_inh_q),
        .inc_en  (1'b1),
        .wr_lo   (csr_we && csr_ofs_ex == CSR_MCYCLE),
        .wr_hi   (csr_we && csr_ofs_ex == CSR_MCYCLEH),
        .wdata   (wdata),
        .count   (mcycle)
    );

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (ir_inh_q),
        .inc_en  (retire & ~stall & ~trap_take),
        .wr_lo   (csr_we && csr_ofs_ex == CSR_MINSTRET),
        .wr_hi   (csr_we && csr_ofs_ex == CSR_MINSTRETH),
        .wdata   (wdata),
        .count   (minstret)
    );

endmodule
